// File: rtl/imem_pkg.sv
// ----------------------------------------------------------------------------
// imem_pkg
//   Shared definitions for the instruction-memory fetch queue.
//   - PC_W           : width of every program-counter value (byte address).
//   - IMEM_DATA_W    : width of the data field carried in a fetch entry.
//   - WORD_SHIFT     : byte-address to word-index shift (4-byte words).
//   - IMEM_RESET_PC  : default fetch address after reset.
//   - fetch_entry_t  : one prefetched instruction {pc, data, fault}.
// ----------------------------------------------------------------------------
package imem_pkg;

  localparam int unsigned PC_W        = 32;
  localparam int unsigned IMEM_DATA_W = 32;
  localparam int unsigned WORD_SHIFT  = 2;

  localparam logic [PC_W-1:0] IMEM_RESET_PC = '0;

  typedef struct packed {
    logic [PC_W-1:0]        pc;
    logic [IMEM_DATA_W-1:0] data;
    logic                   fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
//   Small synchronous FIFO holding prefetched instruction entries.
//   DEPTH must be a power of two so the pointers wrap on their own.
//   Ports:
//     clk        : rising-edge clock
//     reset      : synchronous, active-high; empties the FIFO
//     flush      : synchronous empty (redirect), same effect as reset
//     push       : write push_data at the tail
//     push_data  : entry to write
//     pop        : drop the head entry
//     head_data  : current head entry (meaningful only while count != 0)
//     count      : number of stored entries, 0..DEPTH
// ----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: the storage array has no reset; only pointers and count define
  // which slots hold live data, so clearing it would cost flops for nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      store[wr_ptr] <= push_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every always_ff
  // samples the pre-edge values of the others, exactly like real flops.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  assign head_data = store[rd_ptr];

endmodule

// File: rtl/imem_fetch_queue.sv
// ----------------------------------------------------------------------------
// imem_fetch_queue
//   Instruction fetch unit: a word-addressed instruction memory with a
//   synchronous read port, a fetch PC, and a prefetch FIFO (fetch_fifo)
//   feeding decode with a valid/ready handshake. One instruction per cycle
//   is sustained while decode keeps inst_ready high.
//
//   Fetch pipeline: a fetch issued in cycle N reads memory at the end of N
//   and its entry is pushed into the FIFO at the end of N+1. Issue is
//   throttled so FIFO entries plus the in-flight read never exceed
//   FIFO_DEPTH, so no read result is ever dropped.
//
//   Optional feature (macro IMEM_FAULT_EN): misaligned or out-of-range
//   fetches produce entries with fault=1 and data=0; fetching continues.
//   Without the macro, address bits [1:0] are ignored, the memory is
//   indexed modulo DEPTH and inst_fault is tied to 0.
//
//   Ports:
//     clk            : rising-edge clock
//     reset          : synchronous, active-high
//     redirect_valid : branch/jump redirect strobe (flushes the queue)
//     redirect_pc    : redirect target byte address
//     inst_ready     : decode accepts the head entry
//     inst_valid     : head entry valid
//     inst_data      : head instruction
//     inst_pc        : byte address of inst_data
//     inst_fault     : head entry faulted
// ----------------------------------------------------------------------------
module imem_fetch_queue
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = IMEM_RESET_PC,
  parameter string       INIT_FILE  = "program.hex"
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              inst_ready,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [31:0]       inst_pc,
  output logic              inst_fault
);

  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [PC_W-1:0] DEPTH_PC    = PC_W'(DEPTH);
  localparam logic [CNT_W:0]  FIFO_LIMIT  = (CNT_W + 1)'(FIFO_DEPTH);

  // Instruction memory; contents survive reset.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [PC_W-1:0]   fetch_pc;
  logic [PC_W-1:0]   inflight_pc;
  logic              inflight;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              issue;
  logic              push;
  logic              pop;
  logic              head_valid;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occupancy;
  logic [CNT_W:0]    limit;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;
  logic [$bits(fetch_entry_t)-1:0] head_bits;

  assign rd_addr = ADDR_W'((fetch_pc >> WORD_SHIFT) % DEPTH_PC);

  // A pop this cycle frees a slot in time for a fetch issued this cycle,
  // since that fetch lands two edges later.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
  assign limit     = FIFO_LIMIT + {{CNT_W{1'b0}}, pop};
  assign issue     = !redirect_valid && (occupancy < limit);

  // A redirect discards the read currently in flight.
  assign push = inflight && !redirect_valid;
  assign pop  = head_valid && inst_ready;

`ifdef IMEM_FAULT_EN
  logic issue_fault;
  logic inflight_fault;

  assign issue_fault = (fetch_pc[WORD_SHIFT-1:0] != '0) ||
                       ((fetch_pc >> WORD_SHIFT) >= DEPTH_PC);
`endif

  // Fetch PC and in-flight tracking; reset beats redirect beats issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight_pc <= fetch_pc;
      end
    end
  end

  // Synchronous memory read port.
  always_ff @(posedge clk) begin
    if (issue) begin
      rd_data <= mem[rd_addr];
`ifdef IMEM_FAULT_EN
      inflight_fault <= issue_fault;
`endif
    end
  end

  // NOTE: every field gets a default before any conditional assignment so
  // this block can never infer a latch.
  always_comb begin
    push_entry    = '0;
    push_entry.pc = inflight_pc;
`ifdef IMEM_FAULT_EN
    push_entry.fault = inflight_fault;
    push_entry.data  = inflight_fault ? '0 : IMEM_DATA_W'(rd_data);
`else
    push_entry.data  = IMEM_DATA_W'(rd_data);
`endif
  end

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_bits),
    .count     (fifo_count)
  );

  assign head_entry = fetch_entry_t'(head_bits);

  // Outputs read as zero whenever the head is not valid, including reset.
  assign head_valid = !reset && (fifo_count != '0);
  assign inst_valid = head_valid;
  assign inst_pc    = head_valid ? head_entry.pc : '0;
  assign inst_data  = head_valid ? DATA_W'(head_entry.data) : '0;

`ifdef IMEM_FAULT_EN
  assign inst_fault = head_valid && head_entry.fault;
`else
  logic unused_fault;
  assign unused_fault = head_entry.fault;
  assign inst_fault   = 1'b0;
`endif

endmodule

// File: tb/tb_imem_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_imem_fetch_queue
//   Scoreboard bench for imem_fetch_queue. Each new instruction stream
//   (reset or redirect) loads the queue with the entries expected from the
//   bench's own memory image; a monitor pops and compares on every accepted
//   handshake. Directed checks cover latency, stalls, redirect and reset.
// ----------------------------------------------------------------------------
module tb_imem_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_ready;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_fault;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        fault;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] image [256];

  imem_fetch_queue #(
    .DATA_W     (32),
    .DEPTH      (256),
    .FIFO_DEPTH (4),
    .RESET_PC   (32'h0),
    .INIT_FILE  ("")
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_ready     (inst_ready),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic sb_t model(input logic [31:0] pc);
    sb_t         e;
    logic [31:0] word;
    word = pc >> 2;
    e.pc = pc;
`ifdef IMEM_FAULT_EN
    e.fault = (pc[1:0] != 2'b00) || (word >= 32'd256);
    e.data  = e.fault ? 32'h0 : image[word[7:0]];
`else
    e.fault = 1'b0;
    e.data  = image[word[7:0]];
`endif
    return e;
  endfunction

  task automatic start_stream(input logic [31:0] pc);
    sb_q.delete();
    for (int i = 0; i < 32; i++) begin
      sb_q.push_back(model(pc + 32'(4 * i)));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // First cycle of a stream is cycle 0; entry must appear in cycle 2.
  task automatic expect_first(input logic [31:0] pc);
    @(negedge clk);
    check("lat_cycle0_valid", 32'(inst_valid), 32'd0);
    step();
    @(negedge clk);
    check("lat_cycle1_valid", 32'(inst_valid), 32'd0);
    step();
    @(negedge clk);
    check("lat_first_valid", 32'(inst_valid), 32'd1);
    check("lat_first_pc", inst_pc, pc);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_data", inst_data, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    check("rst_fault", 32'(inst_fault), 32'd0);
    step();
    reset = 1'b0;
    start_stream(32'h0);
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
    start_stream(pc);
    expect_first(pc);
  endtask

  task automatic run_streaming(input int n);
    repeat (n) begin
      @(negedge clk);
      check("stream_no_gap", 32'(inst_valid), 32'd1);
      step();
    end
  endtask

  // Scoreboard monitor: compare every accepted head entry.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (inst_valid && inst_ready) begin
        check("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("sb_pc", inst_pc, e.pc);
          check("sb_data", inst_data, e.data);
          check("sb_fault", 32'(inst_fault), 32'(e.fault));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      image[i] = (i < 4) ? 32'(32'h11 * (i + 1)) : (32'hC0DE_0000 + 32'(i));
      dut.mem[i] = image[i];
    end
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b1;
    step();
    step();

    // Reset release with decode always ready: 0x11, 0x22, 0x33 ...
    reset_pulse();
    expect_first(32'h0);
    step();
    run_streaming(6);

    // Stall for 10 cycles, then drain without gaps or duplicates.
    inst_ready = 1'b0;
    reset_pulse();
    repeat (10) step();
    check("stall_count", 32'(dut.fifo_count), 32'd4);
    check("stall_fetch_pc", dut.fetch_pc, 32'h10);
    @(negedge clk);
    check("stall_head_valid", 32'(inst_valid), 32'd1);
    check("stall_head_pc", inst_pc, 32'h0);
    step();
    inst_ready = 1'b1;
    run_streaming(6);

    // Redirect while three entries are queued and one read is in flight.
    inst_ready = 1'b0;
    reset_pulse();
    repeat (4) step();
    check("pre_redirect_count", 32'(dut.fifo_count), 32'd3);
    redirect_to(32'h40);
    step();
    inst_ready = 1'b1;
    run_streaming(6);

    // Redirect in the same cycle as a pop from a full FIFO.
    inst_ready = 1'b0;
    repeat (6) step();
    check("full_count", 32'(dut.fifo_count), 32'd4);
    inst_ready = 1'b1;
    redirect_to(32'h80);
    step();
    run_streaming(6);

    // Reset in mid-stream with two entries queued.
    inst_ready = 1'b0;
    redirect_to(32'h100);
    step();
    check("pre_reset_count", 32'(dut.fifo_count), 32'd2);
    inst_ready = 1'b1;
    reset_pulse();
    expect_first(32'h0);
    step();
    run_streaming(3);

    // Misaligned, out-of-range and wrapping addresses.
    redirect_to(32'h42);
    step();
    run_streaming(3);
    redirect_to(32'h400);
`ifdef IMEM_FAULT_EN
    check("oob_fault", 32'(inst_fault), 32'd1);
    check("oob_data", inst_data, 32'd0);
`else
    check("oob_fault", 32'(inst_fault), 32'd0);
    check("oob_data", inst_data, 32'h11);
`endif
    step();
    run_streaming(3);
    redirect_to(32'h3F8);
    step();
    run_streaming(4);

    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
